operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage between instruction decode and execute. It accepts one decoded instruction at a time and reads up to two source registers through the register file's single registered read port, one after the other. It snoops the writeback port so every operand reflects the newest committed value, then presents an operand bundle to execute with a valid/ready handshake.

## Interface
- ADDR_WIDTH, 4, register address width; must match the register file.
- DATA_WIDTH, 16, register/operand width.
- CTL_WIDTH, 8, opaque decode control bits passed through unchanged.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs1  in  ADDR_WIDTH  source register A.
- in_rs2  in  ADDR_WIDTH  source register B.
- in_use_rs2  in  1  1: B comes from in_rs2; 0: B comes from in_imm.
- in_imm  in  DATA_WIDTH  immediate operand.
- in_ctl  in  CTL_WIDTH  control bits.
- rf_radr  out  ADDR_WIDTH  register file read address, sampled by the register file at each edge.
- rf_rdata  in  DATA_WIDTH  register file read data, valid 1 cycle after the address.
- wb_we, wb_wadr, wb_din  in  1/ADDR_WIDTH/DATA_WIDTH  copy of the register file write port, for snooping.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_a, out_b  out  DATA_WIDTH  operands.
- out_ctl  out  CTL_WIDTH  registered copy of in_ctl.

## Operation
- States: IDLE, RD1, RD2, DONE. Reset enters IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). An accept is in_valid && in_ready.
- On accept: latch rs1, rs2, use_rs2, imm and ctl, then go to RD1.
- rf_radr:
  - IDLE or DONE: in_rs1, driven combinationally.
  - RD1: latched rs2.
  - RD2: latched rs1. This value is don't-care.
- RD1: capture A. Then go to RD2 if use_rs2; otherwise load B = imm and go to DONE.
- RD2: capture B, then go to DONE.
- DONE: out_valid = 1.
  - On out_ready with an accept: go to RD1 for the new instruction.
  - On out_ready without an accept: go to IDLE.
  - Otherwise hold.
- Forwarding: the register file returns the pre-write value when a read and a write hit the same edge, so the stage forwards.
  - Issue-cycle hit: in the cycle an operand address is driven, if wb_we && wb_wadr == that address, latch wb_din and set a hit flag.
  - Capture priority, highest first: a matching write in the capture cycle, then the issue-cycle latched value, then rf_rdata.
  - Hit flags clear on capture.
- Hold-time update: after A is captured and until the handshake, a matching wb write (wb_wadr == rs1) overwrites out_a. The same applies to out_b when use_rs2 = 1. The immediate B is never overwritten.
- Register address 0 gets no special treatment.
- out_ctl, out_a and out_b change only on capture or a snooped update. They are stable while out_valid && !out_ready, apart from snooped updates.

## Timing
- Reset (asynchronous, immediate), regardless of state:
  - state IDLE, out_valid 0.
  - out_a, out_b, out_ctl and hit flags 0.
  - in_ready 1; rf_radr follows in_rs1.
  - An in-flight instruction is discarded.
- Accept in cycle T0:
  - With use_rs2 = 1: RD1 in T1, RD2 in T2, out_valid first high in T3.
  - With use_rs2 = 0: out_valid first high in T2.
- Throughput: one instruction every 3 cycles with register B, every 2 cycles with an immediate. There are no bubbles when out_ready is held at 1, because a new accept happens in the same cycle as the handshake.
- A write in T0 or T1 to rs1, or in T1 or T2 to rs2, is reflected at out_valid. Writes from T3 onward are reflected in the cycle after they occur.
- Simultaneous capture and snoop on the same operand: the snooped wb_din wins.

## Test plan
- Basic read: preload r3 = 0x1234, r5 = 0x00FF. Accept rs1 = 3, rs2 = 5, use_rs2 = 1, ctl = 0x5A at T0 with out_ready = 1. Expect out_valid high in T3 only, out_a = 0x1234, out_b = 0x00FF, out_ctl = 0x5A.
- Immediate: rs1 = 3, use_rs2 = 0, imm = 0xBEEF. Expect out_valid in T2, out_a = 0x1234, out_b = 0xBEEF.
- Forwarding:
  - Write r3 = 0xAAAA in T0 and r5 = 0x5555 in T2. Expect out_a = 0xAAAA, out_b = 0x5555.
  - Repeat with the r3 write in T1. Expect out_a = 0xAAAA.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Expect in_ready = 0 and outputs stable. Write r3 = 0x7777 in the third cycle; expect out_a = 0x7777 from the next cycle, with out_b unchanged.
- Back-to-back: present 3 register-register instructions with out_ready = 1. Expect the second accept in the same cycle as the first handshake, out_valid at T3, T6 and T9, and correct operands for each.
- Reset mid-operation: deassert reset to 0 during RD2. Expect out_valid = 0 and in_ready = 1 immediately, and no bundle emitted afterwards. After release, a new instruction completes normally.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Signal bundle around the operand-fetch stage: decode handshake, register-file
// read port, writeback snoop and execute handshake.
interface operand_fetch_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CTL_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic                  in_use_rs2;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [CTL_WIDTH-1:0]  in_ctl;

    logic [ADDR_WIDTH-1:0] rf_radr;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_wadr;
    logic [DATA_WIDTH-1:0] wb_din;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [CTL_WIDTH-1:0]  out_ctl;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use_rs2, in_imm, in_ctl,
        input  rf_rdata, wb_we, wb_wadr, wb_din, out_ready,
        output in_ready, rf_radr, out_valid, out_a, out_b, out_ctl
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_use_rs2, in_imm, in_ctl,
        output rf_rdata, wb_we, wb_wadr, wb_din, out_ready,
        input  in_ready, rf_radr, out_valid, out_a, out_b, out_ctl
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads up to two sources through one registered RF read
// port, forwards snooped writebacks, and hands an operand bundle to execute.
//
// state | meaning
// IDLE  | empty, rf_radr = in_rs1, ready for a new instruction
// RD1   | capture A, issue read of rs2
// RD2   | capture B
// DONE  | bundle valid, waiting for out_ready
module operand_fetch #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CTL_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave io_of
);
    typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic                  r_use_rs2;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [CTL_WIDTH-1:0]  r_ctl_lat;
    logic [CTL_WIDTH-1:0]  r_ctl;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_fwd_a;
    logic [DATA_WIDTH-1:0] r_fwd_b;
    logic                  r_hit_a;
    logic                  r_hit_b;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_wb_in_rs1;
    logic                  w_wb_rs1;
    logic                  w_wb_rs2;
    logic [ADDR_WIDTH-1:0] w_radr;

    assign w_in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && io_of.out_ready);
    assign w_accept    = io_of.in_valid && w_in_ready;
    assign w_wb_in_rs1 = io_of.wb_we && (io_of.wb_wadr == io_of.in_rs1);
    assign w_wb_rs1    = io_of.wb_we && (io_of.wb_wadr == r_rs1);
    assign w_wb_rs2    = io_of.wb_we && (io_of.wb_wadr == r_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_radr = io_of.in_rs1;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RD1;
            end
            S_RD1: begin
                w_radr = r_rs2;
                w_next = r_use_rs2 ? S_RD2 : S_DONE;
            end
            S_RD2: begin
                w_radr = r_rs1;
                w_next = S_DONE;
            end
            S_DONE: begin
                if (io_of.out_ready) w_next = w_accept ? S_RD1 : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The RF returns pre-write data on a same-edge read/write, so a write seen
    // while an address is being issued is held aside and preferred at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_use_rs2 <= 1'b0;
            r_imm     <= '0;
            r_ctl_lat <= '0;
            r_ctl     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_fwd_a   <= '0;
            r_fwd_b   <= '0;
            r_hit_a   <= 1'b0;
            r_hit_b   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs1     <= io_of.in_rs1;
                r_rs2     <= io_of.in_rs2;
                r_use_rs2 <= io_of.in_use_rs2;
                r_imm     <= io_of.in_imm;
                r_ctl_lat <= io_of.in_ctl;
                r_hit_a   <= w_wb_in_rs1;
                r_fwd_a   <= io_of.wb_din;
            end
            case (r_state)
                S_RD1: begin
                    r_a     <= w_wb_rs1 ? io_of.wb_din :
                               (r_hit_a ? r_fwd_a : io_of.rf_rdata);
                    r_hit_a <= 1'b0;
                    r_ctl   <= r_ctl_lat;
                    if (r_use_rs2) begin
                        r_hit_b <= w_wb_rs2;
                        r_fwd_b <= io_of.wb_din;
                    end else begin
                        r_b     <= r_imm;
                        r_hit_b <= 1'b0;
                    end
                end
                S_RD2: begin
                    r_b     <= w_wb_rs2 ? io_of.wb_din :
                               (r_hit_b ? r_fwd_b : io_of.rf_rdata);
                    r_hit_b <= 1'b0;
                    if (w_wb_rs1) r_a <= io_of.wb_din;
                end
                S_DONE: begin
                    // Keep the waiting bundle current; an immediate B is never touched.
                    if (!io_of.out_ready) begin
                        if (w_wb_rs1) r_a <= io_of.wb_din;
                        if (r_use_rs2 && w_wb_rs2) r_b <= io_of.wb_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_of.in_ready  = w_in_ready;
    assign io_of.rf_radr   = w_radr;
    assign io_of.out_valid = (r_state == S_DONE);
    assign io_of.out_a     = r_a;
    assign io_of.out_b     = r_b;
    assign io_of.out_ctl   = r_ctl;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file, directed scenarios and
// randomized traffic checked against an architectural-value reference model.
module tb_operand_fetch;
    logic clk;
    logic rst_n;

    operand_fetch_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CTL_WIDTH(8)) ofi ();

    operand_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CTL_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_of (ofi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read, pre-write data on a same-edge collision.
    logic [15:0] mem [16] = '{default: 16'h0};
    always @(posedge clk) begin
        ofi.rf_rdata <= mem[ofi.rf_radr];
        if (ofi.wb_we) mem[ofi.wb_wadr] <= ofi.wb_din;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an accepted instruction becomes valid 3 (reg B) or 2
    // (imm B) cycles later; while valid, its operands equal the current
    // architectural register contents.
    typedef struct {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        use2;
        logic [15:0] imm;
        logic [7:0]  ctl;
        int          acc;
    } ins_t;

    ins_t        q[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          nhs = 0;
    logic        acc_now = 1'b0;
    logic [15:0] last_a, last_b;
    logic [7:0]  last_ctl;

    always begin
        logic exp_valid, exp_ready;
        ins_t n;
        @(negedge clk);
        #2;
        cyc++;
        if (!rst_n) begin
            q.delete();
            acc_now = 1'b0;
            chk("rst_out_valid", ofi.out_valid, 0);
            chk("rst_in_ready", ofi.in_ready, 1);
        end else begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= (q[0].use2 ? 3 : 2));
            chk("out_valid", ofi.out_valid, exp_valid);
            exp_ready = (q.size() == 0) || (exp_valid && ofi.out_ready);
            chk("in_ready", ofi.in_ready, exp_ready);
            if (exp_valid && ofi.out_valid) begin
                chk("out_a", ofi.out_a, mem[q[0].rs1]);
                chk("out_b", ofi.out_b, q[0].use2 ? mem[q[0].rs2] : q[0].imm);
                chk("out_ctl", ofi.out_ctl, q[0].ctl);
                if (ofi.out_ready) begin
                    last_a   = ofi.out_a;
                    last_b   = ofi.out_b;
                    last_ctl = ofi.out_ctl;
                    nhs++;
                    hs_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
            end
            acc_now = ofi.in_valid && ofi.in_ready;
            if (acc_now) begin
                n.rs1 = ofi.in_rs1; n.rs2 = ofi.in_rs2; n.use2 = ofi.in_use_rs2;
                n.imm = ofi.in_imm; n.ctl = ofi.in_ctl; n.acc = cyc;
                q.push_back(n);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ofi.wb_we = 1'b0;
    endtask

    task automatic wbset(input logic [3:0] adr, input logic [15:0] din);
        ofi.wb_we   = 1'b1;
        ofi.wb_wadr = adr;
        ofi.wb_din  = din;
    endtask

    // Called right after tick(); returns at +3 of the accept cycle.
    task automatic send(input logic [3:0] r1, input logic [3:0] r2, input logic u,
                        input logic [15:0] im, input logic [7:0] ct);
        int n = 0;
        ofi.in_valid = 1'b1; ofi.in_rs1 = r1; ofi.in_rs2 = r2;
        ofi.in_use_rs2 = u; ofi.in_imm = im; ofi.in_ctl = ct;
        #3;
        while (!acc_now && n < 20) begin
            tick();
            #3;
            n++;
        end
        chk("send_accept", acc_now, 1);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ofi.in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, h0, hb;
        logic [15:0] a0, b0;
        rst_n = 1'b0;
        ofi.in_valid = 0; ofi.in_rs1 = 4'd9; ofi.in_rs2 = 0; ofi.in_use_rs2 = 0;
        ofi.in_imm = 0; ofi.in_ctl = 0; ofi.wb_we = 0; ofi.wb_wadr = 0; ofi.wb_din = 0;
        ofi.out_ready = 1'b1;
        tick(); #3;
        chk("rst_out_a", ofi.out_a, 0);
        chk("rst_out_b", ofi.out_b, 0);
        chk("rst_out_ctl", ofi.out_ctl, 0);
        chk("rst_radr", ofi.rf_radr, 4'd9);
        tick();
        rst_n = 1'b1;
        tick(); wbset(4'd3, 16'h1234);
        tick(); wbset(4'd5, 16'h00FF);
        idle_n(2);

        // basic register-register read
        tick(); h0 = nhs;
        send(4'd3, 4'd5, 1'b1, 16'h0, 8'h5A); t0 = cyc;
        idle_n(5); #3;
        chk("basic_hs_count", nhs - h0, 1);
        chk("basic_hs_cycle", hs_cyc[hs_cyc.size()-1] - t0, 3);
        chk("basic_a", last_a, 16'h1234);
        chk("basic_b", last_b, 16'h00FF);
        chk("basic_ctl", last_ctl, 8'h5A);

        // immediate operand
        tick(); send(4'd3, 4'd7, 1'b0, 16'hBEEF, 8'h11); t0 = cyc;
        idle_n(4); #3;
        chk("imm_hs_cycle", hs_cyc[hs_cyc.size()-1] - t0, 2);
        chk("imm_a", last_a, 16'h1234);
        chk("imm_b", last_b, 16'hBEEF);

        // forwarding: r3 written in T0, r5 written in T2
        tick(); wbset(4'd3, 16'hAAAA); send(4'd3, 4'd5, 1'b1, 16'h0, 8'h22);
        tick(); ofi.in_valid = 1'b0;
        tick(); wbset(4'd5, 16'h5555);
        idle_n(4); #3;
        chk("fwd0_a", last_a, 16'hAAAA);
        chk("fwd0_b", last_b, 16'h5555);

        // forwarding: r3 written in T1
        tick(); wbset(4'd3, 16'h1111);
        idle_n(1);
        tick(); send(4'd3, 4'd5, 1'b1, 16'h0, 8'h23);
        tick(); ofi.in_valid = 1'b0; wbset(4'd3, 16'hAAAA);
        idle_n(4); #3;
        chk("fwd1_a", last_a, 16'hAAAA);
        chk("fwd1_b", last_b, 16'h5555);

        // backpressure with a snooped write while waiting
        tick(); ofi.out_ready = 1'b0; send(4'd3, 4'd5, 1'b1, 16'h0, 8'h33);
        idle_n(3); #3;
        chk("bp_valid", ofi.out_valid, 1);
        a0 = ofi.out_a; b0 = ofi.out_b;
        tick(); #3;
        chk("bp_in_ready", ofi.in_ready, 0);
        chk("bp_stable_a", ofi.out_a, a0);
        tick(); wbset(4'd3, 16'h7777); #3;
        chk("bp_pre_update_a", ofi.out_a, a0);
        tick(); #3;
        chk("bp_update_a", ofi.out_a, 16'h7777);
        chk("bp_b_unchanged", ofi.out_b, b0);
        chk("bp_b_value", ofi.out_b, 16'h5555);
        tick();
        tick(); ofi.out_ready = 1'b1;
        idle_n(3);

        // three back-to-back register-register instructions
        tick(); wbset(4'd1, 16'h0101);
        tick(); wbset(4'd2, 16'h0202);
        idle_n(1);
        tick(); hb = hs_cyc.size();
        send(4'd1, 4'd2, 1'b1, 16'h0, 8'hA1); t0 = cyc;
        tick(); send(4'd2, 4'd3, 1'b1, 16'h0, 8'hA2);
        tick(); send(4'd3, 4'd1, 1'b1, 16'h0, 8'hA3);
        idle_n(6); #3;
        chk("b2b_count", hs_cyc.size() - hb, 3);
        if (hs_cyc.size() - hb == 3) begin
            chk("b2b_hs1", hs_cyc[hb]   - t0, 3);
            chk("b2b_hs2", hs_cyc[hb+1] - t0, 6);
            chk("b2b_hs3", hs_cyc[hb+2] - t0, 9);
        end
        chk("b2b_last_a", last_a, 16'h7777);
        chk("b2b_last_b", last_b, 16'h0101);

        // reset in RD2 discards the instruction
        tick(); send(4'd1, 4'd2, 1'b1, 16'h0, 8'hC0);
        tick(); ofi.in_valid = 1'b0;
        tick(); rst_n = 1'b0; #3;
        chk("midrst_valid", ofi.out_valid, 0);
        chk("midrst_ready", ofi.in_ready, 1);
        chk("midrst_a", ofi.out_a, 0);
        idle_n(2);
        rst_n = 1'b1;
        h0 = nhs;
        idle_n(5); #3;
        chk("midrst_no_bundle", nhs - h0, 0);
        tick(); send(4'd2, 4'd1, 1'b1, 16'h0, 8'hC1);
        idle_n(5); #3;
        chk("postrst_hs", nhs - h0, 1);
        chk("postrst_a", last_a, 16'h0202);
        chk("postrst_b", last_b, 16'h0101);
        chk("postrst_ctl", last_ctl, 8'hC1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            tick();
            if (!ofi.in_valid || acc_now) begin
                ofi.in_rs1     = 4'($urandom_range(0, 7));
                ofi.in_rs2     = 4'($urandom_range(0, 7));
                ofi.in_use_rs2 = 1'($urandom_range(0, 1));
                ofi.in_imm     = 16'($urandom);
                ofi.in_ctl     = 8'($urandom);
                ofi.in_valid   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 2) == 0) wbset(4'($urandom_range(0, 7)), 16'($urandom));
            ofi.out_ready = ($urandom_range(0, 3) != 0);
        end

        tick(); ofi.in_valid = 1'b0; ofi.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        idle_n(1); #3;
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
